// File: rtl/axis_vid_out.sv
// AXI4-Stream video to native timed video, with a free-running raster and SOF/EOL lock FSM.
// Defining VID_OUT_ERR_CNT_EN adds the saturating err_cnt output.
module axis_vid_out #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
    input  logic                  s_axis_video_tvalid,
    output logic                  s_axis_video_tready,
    input  logic                  s_axis_video_tuser,
    input  logic                  s_axis_video_tlast,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_active_video,
    output logic                  vid_hsync,
    output logic                  vid_vsync,
    output logic                  vid_hblank,
    output logic                  vid_vblank,
    output logic                  locked
`ifdef VID_OUT_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ON  = (SYNC_POL != 0);

    typedef enum logic [1:0] {SEEK, ARMED, LOCKED} state_t;

    state_t          state, state_next;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            h_wrap, origin, active, at_eol;
    logic            consume, underflow, framing, arm_ok;

    assign h_wrap  = (h_cnt == H_LAST);
    assign origin  = (h_cnt == '0) && (v_cnt == '0);
    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign at_eol  = (h_cnt == H_EOL);

    // A beat transfers when tvalid & tready on a rising edge; tready never waits on tvalid
    // except in SEEK, where an SOF beat is held back until the raster reaches (0,0).
    assign consume   = s_axis_video_tvalid & s_axis_video_tready;
    assign underflow = (state == LOCKED) & active & ~s_axis_video_tvalid;
    assign framing   = (state == LOCKED) & consume &
                       ((s_axis_video_tuser != origin) | (s_axis_video_tlast != at_eol));
    assign arm_ok    = s_axis_video_tuser & (s_axis_video_tlast == at_eol);

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEEK:    if (s_axis_video_tvalid && s_axis_video_tuser) state_next = ARMED;
            ARMED:   if (consume) state_next = arm_ok ? LOCKED : SEEK;
            LOCKED:  if (underflow || framing) state_next = SEEK;
            default: state_next = SEEK;
        endcase
    end

    always_comb begin
        s_axis_video_tready = 1'b0;
        locked              = (state == LOCKED);
        if (!rst) begin
            case (state)
                SEEK:    s_axis_video_tready = ~(s_axis_video_tvalid & s_axis_video_tuser);
                ARMED:   s_axis_video_tready = origin;
                LOCKED:  s_axis_video_tready = active;
                default: s_axis_video_tready = 1'b0;
            endcase
        end
    end

    // Raster never stalls on the stream; outputs register the current raster position.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt            <= '0;
            v_cnt            <= '0;
            vid_data         <= '0;
            vid_active_video <= 1'b0;
            vid_hsync        <= ~SYNC_ON;
            vid_vsync        <= ~SYNC_ON;
            vid_hblank       <= 1'b0;
            vid_vblank       <= 1'b0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
            if (h_wrap) begin
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end
            vid_data         <= (consume && state != SEEK) ? s_axis_video_tdata : '0;
            vid_active_video <= active;
            vid_hsync        <= (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
            vid_vsync        <= (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
            vid_hblank       <= (h_cnt >= H_ACT);
            vid_vblank       <= (v_cnt >= V_ACT);
        end
    end

`ifdef VID_OUT_ERR_CNT_EN
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((underflow || framing) && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_vid_out.sv
// Randomized bench for axis_vid_out on a small raster, checked against a raster-position model.
// Error-count checks are compiled only when VID_OUT_ERR_CNT_EN is defined.
module tb_axis_vid_out;
    localparam int DW = 16;
    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FR = HT * VT;
    localparam logic POL = 1'b0;

    typedef struct packed {
        logic          tready;
        logic [DW-1:0] data;
        logic          act;
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic          lk;
        logic [15:0]   err;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic          tready;
    logic [DW-1:0] vid_data;
    logic          vid_active_video, vid_hsync, vid_vsync, vid_hblank, vid_vblank, locked;
`ifdef VID_OUT_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    obs_t obs_s, exp_s;

    // Model: raster position is derived from cycles since reset; mode 0=seek 1=armed 2=locked.
    int            m_t = 0, m_mode = 0, m_err = 0;
    int            src_idx = 0;
    logic [DW-1:0] src_data = '0;
    int            inj_kind = 0, inj_h = 0, inj_v = 0;
    bit            inj_done = 1'b1;

    axis_vid_out #(
        .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(0)
    ) dut (
        .pixel_clk(clk),
        .rst(rst),
        .s_axis_video_tdata(tdata),
        .s_axis_video_tvalid(tvalid),
        .s_axis_video_tready(tready),
        .s_axis_video_tuser(tuser),
        .s_axis_video_tlast(tlast),
        .vid_data(vid_data),
        .vid_active_video(vid_active_video),
        .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync),
        .vid_hblank(vid_hblank),
        .vid_vblank(vid_vblank),
        .locked(locked)
`ifdef VID_OUT_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One pixel clock: drive a beat from the frame source, predict, then capture the DUT.
    task automatic step(input bit r, input bit vld);
        int h, v, nxt;
        bit org, act, rdy, cons, v_i, u_i, l_i, eol;
        h   = m_t % HT;
        v   = (m_t / HT) % VT;
        org = (h == 0) && (v == 0);
        act = (h < HA) && (v < VA);
        eol = (h == HA - 1);
        v_i = vld;
        u_i = (src_idx == 0);
        l_i = ((src_idx % HA) == HA - 1);
        if (!r && !inj_done && m_mode == 2 && h == inj_h && v == inj_v) begin
            inj_done = 1'b1;
            case (inj_kind)
                1: v_i = 1'b0;
                2: l_i = 1'b1;
                3: u_i = 1'b1;
                default: ;
            endcase
        end
        rst = r; tvalid = v_i; tuser = u_i; tlast = l_i; tdata = src_data;
        #1;
        obs_s.tready = tready;
        nxt = m_mode;
        rdy = 1'b0;
        if (r) begin
            nxt = 0;
        end else if (m_mode == 0) begin
            rdy = !(v_i && u_i);
            if (v_i && u_i) nxt = 1;
        end else if (m_mode == 1) begin
            rdy = org;
            if (v_i && org) nxt = (u_i && (l_i == eol)) ? 2 : 0;
        end else begin
            rdy = act;
            if (act && (!v_i || u_i != org || l_i != eol)) begin
                nxt = 0;
                m_err = (m_err < 65535) ? m_err + 1 : m_err;
            end
        end
        cons = v_i && rdy;
        exp_s.tready = rdy;
        exp_s.data   = (cons && m_mode != 0) ? src_data : '0;
        exp_s.act    = !r && act;
        exp_s.hs     = (!r && h >= HA + HFP && h < HA + HFP + HSY) ? POL : ~POL;
        exp_s.vs     = (!r && v >= VA + VFP && v < VA + VFP + VSY) ? POL : ~POL;
        exp_s.hb     = !r && (h >= HA);
        exp_s.vb     = !r && (v >= VA);
        exp_s.lk     = (nxt == 2);
        if (r) m_err = 0;
`ifdef VID_OUT_ERR_CNT_EN
        exp_s.err = 16'(m_err);
`else
        exp_s.err = 16'd0;
`endif
        m_mode = nxt;
        m_t    = r ? 0 : m_t + 1;
        if (cons) begin
            src_idx  = (src_idx + 1) % (HA * VA);
            src_data = DW'($urandom);
        end
        @(posedge clk);
        #1;
        obs_s.data = vid_data; obs_s.act = vid_active_video;
        obs_s.hs = vid_hsync; obs_s.vs = vid_vsync;
        obs_s.hb = vid_hblank; obs_s.vb = vid_vblank; obs_s.lk = locked;
`ifdef VID_OUT_ERR_CNT_EN
        obs_s.err = err_cnt;
`else
        obs_s.err = 16'd0;
`endif
    endtask

    task automatic test_reset();
        repeat (3) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL reset got %h exp %h", obs_s, exp_s);
            end
        end
        checks++;
        if (vid_hsync !== 1'b1 || vid_vsync !== 1'b1 || locked !== 1'b0 || vid_data !== '0) begin
            errors++; $display("FAIL reset_values got hs=%b vs=%b lk=%b d=%h exp 1 1 0 0",
                               vid_hsync, vid_vsync, locked, vid_data);
        end
    endtask

    task automatic test_idle();
        repeat (2 * FR) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL idle t=%0d got %h exp %h", m_t, obs_s, exp_s);
            end
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL idle_lock got %b exp 0", locked);
        end
    endtask

    task automatic test_stream();
        src_idx = 0;
        step(1'b1, 1'b0);
        repeat (4 * FR) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL stream t=%0d got %h exp %h", m_t, obs_s, exp_s);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL stream_lock got %b exp 1", locked);
        end
    endtask

    task automatic test_junk();
        step(1'b1, 1'b0);
        repeat ($urandom_range(10, 50)) step(1'b0, 1'b0);
        src_idx = HA * VA - 3;
        repeat (3 * FR) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL junk t=%0d got %h exp %h", m_t, obs_s, exp_s);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL junk_lock got %b exp 1", locked);
        end
    endtask

    // kind 1 = tvalid gap, 2 = early tlast, 3 = stray tuser; one error then relock.
    task automatic test_inject(input int kind);
        step(1'b1, 1'b0);
        inj_kind = kind;
        inj_v    = $urandom_range(0, VA - 1);
        case (kind)
            2:       inj_h = HA - 2;
            3:       inj_h = $urandom_range(1, HA - 1);
            default: inj_h = $urandom_range(0, HA - 1);
        endcase
        inj_done = 1'b0;
        repeat (5 * FR) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL inject%0d t=%0d got %h exp %h", kind, m_t, obs_s, exp_s);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL inject%0d_relock got %b exp 1", kind, locked);
        end
`ifdef VID_OUT_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd1) begin
            errors++; $display("FAIL inject%0d_err_cnt got %0d exp 1", kind, err_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int guard;
        step(1'b1, 1'b0);
        repeat (2 * FR) step(1'b0, 1'b1);
        guard = 0;
        while (((m_t / HT) % VT) != 2 && guard < FR) begin
            step(1'b0, 1'b1);
            guard++;
        end
        checks++;
        if (guard >= FR) begin
            errors++; $display("FAIL mid_reset_timeout got %0d exp <%0d", guard, FR);
        end
        repeat (2) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL mid_reset got %h exp %h", obs_s, exp_s);
            end
        end
        repeat (3 * FR) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL mid_reset_run t=%0d got %h exp %h", m_t, obs_s, exp_s);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL mid_reset_relock got %b exp 1", locked);
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0);
        repeat (6 * FR) begin
            step(1'b0, $urandom_range(0, 99) < 90);
            checks++;
            if (obs_s !== exp_s) begin
                errors++; $display("FAIL random t=%0d got %h exp %h", m_t, obs_s, exp_s);
            end
        end
    endtask

    initial begin
        src_data = DW'($urandom);
        @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_stream();
        test_junk();
        test_inject(1);
        test_inject(2);
        test_inject(3);
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_vid_out.md
AXIS_VID_OUT -- requirements
Module: axis_vid_out

Interface
- REQ-001: Parameters (name, default, meaning), SHALL be exactly:
  - DATA_WIDTH, 24, pixel width in bits.
  - H_ACTIVE, 640, active pixels per line.
  - H_FP, 16, horizontal front porch.
  - H_SYNC, 96, horizontal sync width.
  - H_BP, 48, horizontal back porch.
  - V_ACTIVE, 480, active lines.
  - V_FP, 10, vertical front porch.
  - V_SYNC, 2, vertical sync width.
  - V_BP, 33, vertical back porch.
  - SYNC_POL, 0, sync active level (0 = active-low).
- REQ-002: Ports (name, direction, width, meaning) SHALL be exactly:
  - pixel_clk, in, 1, single clock; reset is synchronous and active-high.
  - rst, in, 1, synchronous active-high reset.
  - s_axis_video_tdata, in, DATA_WIDTH, pixel data.
  - s_axis_video_tvalid, in, 1, beat valid.
  - s_axis_video_tready, out, 1, beat ready.
  - s_axis_video_tuser, in, 1, start of frame (SOF).
  - s_axis_video_tlast, in, 1, end of line (EOL).
  - vid_data, out, DATA_WIDTH, native video data.
  - vid_active_video, out, 1, data enable.
  - vid_hsync, out, 1, horizontal sync.
  - vid_vsync, out, 1, vertical sync.
  - vid_hblank, out, 1, horizontal blank.
  - vid_vblank, out, 1, vertical blank.
  - locked, out, 1, stream aligned to timing.

Function
- REQ-003: Totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP.
- REQ-004: Counters SHALL behave as follows:
  - h_cnt SHALL count 0..H_TOTAL-1 every cycle and wrap to 0.
  - v_cnt SHALL increment when h_cnt wraps, and SHALL wrap to 0 after V_TOTAL-1.
- REQ-005: The active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- REQ-006: Sync SHALL be asserted (level SYNC_POL) as follows:
  - hsync for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- REQ-007: hblank SHALL equal h_cnt>=H_ACTIVE, and vblank SHALL equal v_cnt>=V_ACTIVE.
- REQ-008: All vid_* outputs SHALL be registered, with exactly 1-cycle latency from counter state; all vid_* outputs SHALL be mutually aligned.
- REQ-009: The state machine SHALL have states SEEK, ARMED and LOCKED; locked SHALL be 1 only in LOCKED.
- REQ-010: In SEEK:
  - tready SHALL equal !(tvalid & tuser), so non-SOF beats are discarded.
  - On tvalid & tuser the state SHALL go to ARMED without consuming the beat.
- REQ-011: In ARMED:
  - tready SHALL be 0 except at h_cnt=0 and v_cnt=0.
  - At h_cnt=0, v_cnt=0 with tvalid & tuser: tready SHALL be 1, the beat SHALL be consumed, and the state SHALL go to LOCKED.
  - At h_cnt=0, v_cnt=0 with !tvalid: the state SHALL stay ARMED.
- REQ-012: In LOCKED, tready SHALL be 1 exactly in the active region.
- REQ-013: Each consumed beat SHALL appear on vid_data with vid_active_video=1 one cycle later.
- REQ-014: An underflow (LOCKED, active region, !tvalid) SHALL:
  - output vid_data=0 for that pixel;
  - go to SEEK next cycle;
  - let the timing continue unaffected.
- REQ-015: A framing error SHALL go to SEEK after consuming the offending beat. Framing errors in LOCKED are:
  - tuser=1 on any pixel other than (0,0);
  - tuser=0 at (0,0);
  - tlast != (h_cnt==H_ACTIVE-1).
- REQ-016: vid_data SHALL be 0 whenever the pixel was not consumed (SEEK, ARMED, blanking, underflow); vid_active_video SHALL follow the active region regardless of state.
- REQ-017: Simultaneous underflow and wrap SHALL cause no counter disturbance; counters are never stalled by the stream.

Reset
- REQ-018: On rst=1 at a pixel_clk edge, the block SHALL set:
  - h_cnt=0, v_cnt=0, state=SEEK;
  - vid_data=0, vid_active_video=0, vid_hblank=0, vid_vblank=0;
  - vid_hsync=vid_vsync=!SYNC_POL;
  - locked=0.
- REQ-019: While rst=1, s_axis_video_tready SHALL be 0.
- REQ-020: Reset mid-frame SHALL abandon the frame and restart timing at (0,0) on the first cycle after release.

Configuration
- REQ-021: With VID_OUT_ERR_CNT_EN defined:
  - An extra output err_cnt (out, 16, error count) SHALL exist.
  - err_cnt SHALL increment by 1 per underflow or framing-error event, saturating at 16'hFFFF.
  - err_cnt SHALL be cleared by rst.
- REQ-022: Without VID_OUT_ERR_CNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
- REQ-023: Reset released, stream idle → hsync low for 96 cycles starting 656 cycles into each 800-cycle line; vsync low on lines 490-491 of 525; locked=0.
- REQ-024: Continuous valid stream, SOF and EOL correct, data = pixel index → locked=1 from the first frame; vid_data follows the index with 1-cycle latency; no gaps.
- REQ-025: Three junk beats (tuser=0), then an SOF beat mid-frame → junk discarded, tready=0 until (0,0), then lock.
- REQ-026: tvalid dropped at pixel (100,5) → vid_data=0 for that pixel, locked=0 next cycle, relock at the next frame; err_cnt=1 with the macro defined.
- REQ-027: tlast asserted at pixel 638 → SEEK after that beat; err_cnt increments.
- REQ-028: rst pulsed at line 200 → outputs at reset values; h_cnt=v_cnt=0 after release; locked=0 until the next SOF.
